mem_stage_hs: RTL and testbench

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

---
 rtl/mem_stage_hs_pkg.sv | 33 +++
 rtl/mem_load_align.sv | 42 ++++
 rtl/mem_stage_hs.sv | 140 ++++++++++++++
 tb/tb_mem_stage_hs.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_hs_pkg.sv
// Shared bus layouts, load_op bit positions and load FSM states for the MEM stage.
package mem_stage_hs_pkg;

   localparam int ES_TO_MS_BUS_WD   = 111;
   localparam int MS_TO_WS_BUS_WD   = 70;
   localparam int MS_FWD_BLK_BUS_WD = 42;

   localparam int LOP_LB  = 0;
   localparam int LOP_LBU = 1;
   localparam int LOP_LH  = 2;
   localparam int LOP_LHU = 3;
   localparam int LOP_LW  = 4;
   localparam int LOP_LWL = 5;
   localparam int LOP_LWR = 6;

   typedef enum logic [1:0] {
      LS_IDLE = 2'd0,
      LS_WAIT = 2'd1,
      LS_DONE = 2'd2
   } load_state_e;

   typedef struct packed {
      logic [6:0]  load_op;
      logic        req_sent;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] exe_result;
      logic [31:0] rt_old;
      logic [31:0] pc;
   } es_to_ms_t;

endpackage

// File: rtl/mem_load_align.sv
// Byte-lane extraction, sign/zero extension and lwl/lwr merge for load data.
module mem_load_align
   import mem_stage_hs_pkg::*;
#(
   parameter bit LWLR_EN = 1'b1
) (
   input  logic [6:0]  load_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   input  logic [31:0] rt_old,
   output logic [31:0] result
);

   logic [4:0]  sh_lo;
   logic [4:0]  sh_hi;
   logic [31:0] byte_lane;
   logic [31:0] half_lane;

   // sh_hi is 8*(3-addr): lwl shifts the low bytes up into the top of the word
   assign sh_lo     = {addr, 3'b000};
   assign sh_hi     = {~addr, 3'b000};
   assign byte_lane = rdata >> sh_lo;
   assign half_lane = rdata >> {addr[1], 4'b0000};

   always_comb begin
      result = rdata;
      if (load_op[LOP_LB]) begin
         result = {{24{byte_lane[7]}}, byte_lane[7:0]};
      end else if (load_op[LOP_LBU]) begin
         result = {24'h0, byte_lane[7:0]};
      end else if (load_op[LOP_LH]) begin
         result = {{16{half_lane[15]}}, half_lane[15:0]};
      end else if (load_op[LOP_LHU]) begin
         result = {16'h0, half_lane[15:0]};
      end else if (LWLR_EN && load_op[LOP_LWL]) begin
         result = (rdata << sh_hi) | (rt_old & ~(32'hFFFF_FFFF << sh_hi));
      end else if (LWLR_EN && load_op[LOP_LWR]) begin
         result = (rdata >> sh_lo) | (rt_old & ~(32'hFFFF_FFFF >> sh_lo));
      end
   end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds one instruction, waits for its load response (buffering it
// when WB stalls) and discards responses that belong to flushed or cancelled loads.
module mem_stage_hs
   import mem_stage_hs_pkg::*;
#(
   parameter int OUT_MAX = 2,
   parameter bit LWLR_EN = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ws_allowin,
   output logic                         ms_allowin,
   input  logic                         es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
   output logic                         ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
   input  logic                         ms_flush,
   input  logic                         es_req_cancel,
   input  logic                         data_sram_data_ok,
   input  logic [31:0]                  data_sram_rdata,
   output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

   localparam int DW = (OUT_MAX < 1) ? 1 : $clog2(OUT_MAX + 1);
   localparam logic [DW:0] DISC_MAX = (DW + 1)'(OUT_MAX);

   logic        ms_valid_q,  ms_valid_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] rdata_buf_q, rdata_buf_d;
   es_to_ms_t   bus_q,       bus_d;
   load_state_e state_q,     state_d;
   logic [DW-1:0] discard_cnt_q, discard_cnt_d;

   es_to_ms_t   new_bus;
   logic        new_wait;
   logic        wait_load;
   logic        in_wait;
   logic        data_ok_acc;
   logic        ms_ready_go;
   logic        inc_flush;
   logic        dec_disc;
   logic [DW:0] disc_sum;
   logic [31:0] rdata_sel;
   logic [31:0] load_result;
   logic [31:0] final_result;
   logic        ms_blk;
   logic [3:0]  fwd_valid;

   assign new_bus     = es_to_ms_t'(es_to_ms_bus);
   assign new_wait    = (|new_bus.load_op) & new_bus.req_sent;
   assign wait_load   = (|bus_q.load_op) & bus_q.req_sent;
   assign in_wait     = (state_q == LS_WAIT);
   assign data_ok_acc = data_sram_data_ok & (discard_cnt_q == '0);

   assign ms_ready_go    = !wait_load | buf_valid_q | data_ok_acc;
   assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
   assign ms_to_ws_valid = ms_valid_q & ms_ready_go & !ms_flush;

   // Flush wins over entry; a free slot (ms_allowin) means the current instruction leaves
   always_comb begin
      ms_valid_d  = ms_valid_q;
      buf_valid_d = buf_valid_q;
      rdata_buf_d = rdata_buf_q;
      bus_d       = bus_q;
      state_d     = state_q;
      if (ms_flush) begin
         ms_valid_d  = 1'b0;
         buf_valid_d = 1'b0;
         state_d     = LS_IDLE;
      end else if (ms_allowin) begin
         ms_valid_d  = es_to_ms_valid;
         buf_valid_d = 1'b0;
         state_d     = (es_to_ms_valid & new_wait) ? LS_WAIT : LS_IDLE;
         if (es_to_ms_valid) begin
            bus_d = new_bus;
         end
      end else if (in_wait & data_ok_acc) begin
         buf_valid_d = 1'b1;
         rdata_buf_d = data_sram_rdata;
         state_d     = LS_DONE;
      end
   end

   // A flushed load still owes a response unless it arrived this very cycle
   assign inc_flush = ms_flush & in_wait & !data_ok_acc;
   assign dec_disc  = data_sram_data_ok & (discard_cnt_q != '0);
   assign disc_sum  = {1'b0, discard_cnt_q}
                    + {{DW{1'b0}}, inc_flush}
                    + {{DW{1'b0}}, es_req_cancel}
                    - {{DW{1'b0}}, dec_disc};
   assign discard_cnt_d = disc_sum[DW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid_q    <= 1'b0;
         buf_valid_q   <= 1'b0;
         state_q       <= LS_IDLE;
         discard_cnt_q <= '0;
      end else begin
         ms_valid_q    <= ms_valid_d;
         buf_valid_q   <= buf_valid_d;
         state_q       <= state_d;
         discard_cnt_q <= discard_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (disc_sum <= DISC_MAX)
            else $error("mem_stage_hs: discard count exceeds OUT_MAX");
      end
   end
`endif

   assign rdata_sel = buf_valid_q ? rdata_buf_q : data_sram_rdata;

   mem_load_align #(
      .LWLR_EN (LWLR_EN)
   ) u_align (
      .load_op (bus_q.load_op),
      .addr    (bus_q.exe_result[1:0]),
      .rdata   (rdata_sel),
      .rt_old  (bus_q.rt_old),
      .result  (load_result)
   );

   assign final_result = bus_q.res_from_mem ? load_result : bus_q.exe_result;
   assign ms_to_ws_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};

   assign fwd_valid      = {4{ms_valid_q & bus_q.gr_we & ms_ready_go}};
   assign ms_blk         = ms_valid_q & bus_q.gr_we & bus_q.res_from_mem & !ms_ready_go;
   assign ms_fwd_blk_bus = {ms_blk, fwd_valid, bus_q.dest, final_result};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs with a scoreboard of expected WB transfers.
module tb_mem_stage_hs;
   import mem_stage_hs_pkg::*;

   logic                         clk = 1'b0;
   logic                         reset;
   logic                         ws_allowin;
   logic                         ms_allowin;
   logic                         es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
   logic                         ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
   logic                         ms_flush;
   logic                         es_req_cancel;
   logic                         data_sram_data_ok;
   logic [31:0]                  data_sram_rdata;
   logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;

   int vectors = 0;
   int miscompares = 0;
   logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];
   logic [MS_TO_WS_BUS_WD-1:0] obs_q[$];

   mem_stage_hs dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_flush          (ms_flush),
      .es_req_cancel     (es_req_cancel),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_fwd_blk_bus    (ms_fwd_blk_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   // Record a WB transfer at the falling edge, then advance past the next rising edge
   task automatic tick();
      @(negedge clk);
      if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) obs_q.push_back(ms_to_ws_bus);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] lop(input int i);
      logic [6:0] one;
      one = 7'd1;
      return one << i;
   endfunction

   function automatic logic [MS_TO_WS_BUS_WD-1:0] ws(input logic [31:0] res, input logic [31:0] pc);
      return {1'b1, 5'd3, res, pc};
   endfunction

   task automatic enter(input logic [6:0] op, input logic req, input logic rfm,
                        input logic [31:0] exe, input logic [31:0] rt, input logic [31:0] pc);
      check("allowin before entry", ms_allowin, 1'b1);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = {op, req, rfm, 1'b1, 5'd3, exe, rt, pc};
      tick();
      es_to_ms_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (obs_q.size() > 0 && exp_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
      check({tag, " pending"}, exp_q.size(), 0);
      check({tag, " extra"}, obs_q.size(), 0);
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic do_load(input string tag, input int op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] rt,
                          input logic [31:0] exp_res, input logic [31:0] pc);
      enter(lop(op), 1'b1, 1'b1, addr, rt, pc);
      check({tag, " blk while waiting"}, ms_fwd_blk_bus[41], 1'b1);
      check({tag, " no early valid"}, ms_to_ws_valid, 1'b0);
      exp_q.push_back(ws(exp_res, pc));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      drain(tag);
   endtask

   initial begin
      reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      ms_flush = 1'b0; es_req_cancel = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      #1;
      check("reset allowin", ms_allowin, 1'b1);
      check("reset ws_valid", ms_to_ws_valid, 1'b0);
      check("reset blk", ms_fwd_blk_bus[41], 1'b0);
      check("reset fwd_valid", ms_fwd_blk_bus[40:37], 4'h0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // ALU result passes straight through and forwards
      enter(7'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hBFC0_0000);
      check("alu fwd_valid", ms_fwd_blk_bus[40:37], 4'hF);
      check("alu fwd data", ms_fwd_blk_bus[31:0], 32'h1234_5678);
      check("alu ws_valid", ms_to_ws_valid, 1'b1);
      exp_q.push_back(ws(32'h1234_5678, 32'hBFC0_0000));
      tick();
      drain("alu");

      do_load("lb a3",  LOP_LB,  32'h1000_0003, 32'h80FF_0000, 32'h0, 32'hFFFF_FF80, 32'hBFC0_0010);
      do_load("lbu a3", LOP_LBU, 32'h1000_0003, 32'h80FF_0000, 32'h0, 32'h0000_0080, 32'hBFC0_0014);
      do_load("lh a2",  LOP_LH,  32'h1000_0002, 32'h8001_1234, 32'h0, 32'hFFFF_8001, 32'hBFC0_0018);
      do_load("lhu a0", LOP_LHU, 32'h1000_0000, 32'h0000_9ABC, 32'h0, 32'h0000_9ABC, 32'hBFC0_001C);
      do_load("lwl a1", LOP_LWL, 32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344, 32'hBFC0_0020);
      do_load("lwr a2", LOP_LWR, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB, 32'hBFC0_0024);

      // lw whose response arrives while WB is stalled
      enter(lop(LOP_LW), 1'b1, 1'b1, 32'h1000_0000, 32'h0, 32'hBFC0_0030);
      tick(); tick();
      ws_allowin = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1234_5678;
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_BEEF;
      check("stall buf_valid", dut.buf_valid_q, 1'b1);
      check("stall blk", ms_fwd_blk_bus[41], 1'b0);
      check("stall fwd data", ms_fwd_blk_bus[31:0], 32'h1234_5678);
      tick();
      check("stall no output", obs_q.size(), 0);
      exp_q.push_back(ws(32'h1234_5678, 32'hBFC0_0030));
      ws_allowin = 1'b1;
      tick(); tick(); tick();
      drain("stall release");

      // flush in second WAIT cycle plus a cancel: two stale responses follow
      enter(lop(LOP_LW), 1'b1, 1'b1, 32'h1000_0004, 32'h0, 32'hBFC0_0040);
      tick();
      ms_flush = 1'b1;
      es_req_cancel = 1'b1;
      tick();
      ms_flush = 1'b0;
      es_req_cancel = 1'b0;
      check("flush discard_cnt", dut.discard_cnt_q, 2'd2);
      check("flush allowin", ms_allowin, 1'b1);
      enter(lop(LOP_LW), 1'b1, 1'b1, 32'h1000_0008, 32'h0, 32'hBFC0_0048);
      exp_q.push_back(ws(32'hCAFE_F00D, 32'hBFC0_0048));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1111_1111;
      check("stale1 ignored", ms_to_ws_valid, 1'b0);
      tick();
      check("discard after stale1", dut.discard_cnt_q, 2'd1);
      data_sram_rdata = 32'h2222_2222;
      check("stale2 ignored", ms_to_ws_valid, 1'b0);
      tick();
      check("discard after stale2", dut.discard_cnt_q, 2'd0);
      data_sram_data_ok = 1'b0;
      tick();
      check("third load blk", ms_fwd_blk_bus[41], 1'b1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hCAFE_F00D;
      tick();
      data_sram_data_ok = 1'b0;
      drain("after discard");

      // flush and response in the same cycle
      enter(lop(LOP_LW), 1'b1, 1'b1, 32'h1000_000C, 32'h0, 32'hBFC0_0050);
      ms_flush = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555_5555;
      check("flush+ok ws_valid", ms_to_ws_valid, 1'b0);
      tick();
      ms_flush = 1'b0;
      data_sram_data_ok = 1'b0;
      check("flush+ok discard_cnt", dut.discard_cnt_q, 2'd0);
      check("flush+ok ws_valid after", ms_to_ws_valid, 1'b0);
      tick();
      drain("flush+ok");

      // asynchronous reset mid-WAIT
      enter(lop(LOP_LW), 1'b1, 1'b1, 32'h1000_0010, 32'h0, 32'hBFC0_0060);
      tick();
      check("pre-reset blk", ms_fwd_blk_bus[41], 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async reset allowin", ms_allowin, 1'b1);
      check("async reset ws_valid", ms_to_ws_valid, 1'b0);
      check("async reset blk", ms_fwd_blk_bus[41], 1'b0);
      check("async reset fwd_valid", ms_fwd_blk_bus[40:37], 4'h0);
      check("async reset discard", dut.discard_cnt_q, 2'd0);
      tick();
      reset = 1'b0;
      tick();
      enter(7'd0, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, 32'hBFC0_0070);
      exp_q.push_back(ws(32'h0BAD_F00D, 32'hBFC0_0070));
      tick();
      drain("after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
